// File: rtl/sync_cnt_pkg.sv
// Shared defaults and helpers for the T-FF counter family.
package sync_cnt_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MATCH_A = 3;
    localparam int DEFAULT_MATCH_B = 9;

    // Largest unsigned value representable in w bits (w up to 31).
    function automatic int all_ones(input int w);
        logic [32:0] v;
        v = (33'd1 << w) - 33'd1;
        return int'(v[31:0]);
    endfunction

endpackage

// File: rtl/t_ff_sync.sv
// One counter bit: T flip-flop with synchronous active-low reset to a
// per-bit reset value and a synchronous parallel load.
module t_ff_sync (
    input  logic clk,
    input  logic reset,
    input  logic rst_val_i,
    input  logic load_i,
    input  logic d_i,
    input  logic t_i,
    output logic q_o
);

    logic bit_q;
    logic bit_d;

    // Next state: reset dominates, then load, then toggle.
    always_comb begin
        bit_d = bit_q;
        if (!reset) begin
            bit_d = rst_val_i;
        end else if (load_i) begin
            bit_d = d_i;
        end else if (t_i) begin
            bit_d = ~bit_q;
        end else begin
            bit_d = bit_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        bit_q <= bit_d;
    end

    assign q_o = bit_q;

endmodule

// File: rtl/sync_down_counter_tff.sv
// Down counter built from T-FF cells with wrap/saturate, decode and terminal count.
// Optional macro SYNC_DOWN_CNT_YREG_EN registers the decode output y.
module sync_down_counter_tff
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MATCH_A   = DEFAULT_MATCH_A,
    parameter int MATCH_B   = DEFAULT_MATCH_B,
    parameter int RESET_VAL = all_ones(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             stop_at_zero,
    output logic [WIDTH-1:0] q,
    output logic             y,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST_Q   = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MATCH_A_Q = MATCH_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MATCH_B_Q = MATCH_B[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] t_s;
    logic             zero_s;
    logic             cnt_en_s;
    logic             match_s;

    assign zero_s   = (cnt_q == {WIDTH{1'b0}});
    // Saturation freezes every toggle at zero; otherwise all cells flip to all ones.
    assign cnt_en_s = en & ~load & ~(stop_at_zero & zero_s);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign t_s[i] = cnt_en_s;
        end else begin : g_upper
            assign t_s[i] = cnt_en_s & (cnt_q[i-1:0] == {i{1'b0}});
        end

        t_ff_sync u_cell (
            .clk       (clk),
            .reset     (reset),
            .rst_val_i (RST_Q[i]),
            .load_i    (load),
            .d_i       (d[i]),
            .t_i       (t_s[i]),
            .q_o       (cnt_q[i])
        );
    end

    assign match_s = (cnt_q == MATCH_A_Q) | (cnt_q == MATCH_B_Q);

    assign q    = cnt_q;
    assign zero = zero_s;
    assign tc   = en & ~load & reset & zero_s;

`ifdef SYNC_DOWN_CNT_YREG_EN
    logic y_q;
    logic y_d;

    // Registered decode, cleared on load so a stale match never survives a jump.
    always_comb begin
        y_d = 1'b0;
        if (load) begin
            y_d = 1'b0;
        end else begin
            y_d = match_s;
        end
    end

    // Decode register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;
`else
    assign y = match_s;
`endif

endmodule

// File: tb/tb_sync_down_counter_tff.sv
// Randomised and directed bench for sync_down_counter_tff against an arithmetic model.
module tb_sync_down_counter_tff;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] d;
    logic       stop_at_zero;
    logic [3:0] q;
    logic       y;
    logic       tc;
    logic       zero;

    int n_cmp;
    int n_err;
    int m_q;
    bit m_valid;
    bit m_yreg;

    sync_down_counter_tff dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .load         (load),
        .d            (d),
        .stop_at_zero (stop_at_zero),
        .q            (q),
        .y            (y),
        .tc           (tc),
        .zero         (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_match(input int v);
        return (v == 3) || (v == 9);
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit r, input bit ld, input bit e, input int dv, input bit sz);
        int exp_y;
        reset = r; load = ld; en = e; d = 4'(dv); stop_at_zero = sz;
        #1;
        if (m_valid) begin
            cmp("q", int'(q), m_q);
            cmp("zero", int'(zero), int'(m_q == 0));
            cmp("tc", int'(tc), int'(e && !ld && r && m_q == 0));
`ifdef SYNC_DOWN_CNT_YREG_EN
            exp_y = int'(m_yreg);
`else
            exp_y = int'(is_match(m_q));
`endif
            cmp("y", int'(y), exp_y);
        end
        @(posedge clk);
        if (!r) begin
            m_yreg = 1'b0;
            m_q = 15;
            m_valid = 1'b1;
        end else if (ld) begin
            m_yreg = 1'b0;
            m_q = dv;
        end else begin
            m_yreg = is_match(m_q);
            if (e) begin
                if (m_q == 0) m_q = sz ? 0 : 15;
                else m_q = m_q - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_q = 0; m_valid = 1'b0; m_yreg = 1'b0;
        reset = 1'b0; load = 1'b0; en = 1'b1; d = 4'd0; stop_at_zero = 1'b0;
        @(negedge clk);

        // Reset held for two cycles.
        cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);
        reset = 1'b0; #1;
        cmp("pin_rst_q", int'(q), 15);
        cmp("pin_rst_zero", int'(zero), 0);
        cmp("pin_rst_tc", int'(tc), 0);
`ifndef SYNC_DOWN_CNT_YREG_EN
        cmp("pin_rst_y", int'(y), 0);
`endif

        // Count down 15 -> 0 through both decode values.
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b1, 0, 1'b0);
        cmp("pin_at_zero", int'(q), 0);

        // Wrap: tc for one cycle then all ones.
        en = 1'b1; load = 1'b0; reset = 1'b1; stop_at_zero = 1'b0; #1;
        cmp("pin_wrap_tc", int'(tc), 1);
        cycle(1'b1, 1'b0, 1'b1, 0, 1'b0);
        cmp("pin_wrap_q", int'(q), 15);
        cmp("pin_wrap_zero", int'(zero), 0);

        // Saturate: reach zero and stay there for five enabled cycles.
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; #1;
            cmp("pin_sat_tc", int'(tc), 1);
            cycle(1'b1, 1'b0, 1'b1, 0, 1'b1);
            cmp("pin_sat_q", int'(q), 0);
        end

        // Load beats enable.
        cycle(1'b1, 1'b1, 1'b0, 10, 1'b0);
        cmp("pin_load10", int'(q), 10);
        load = 1'b1; en = 1'b1; d = 4'd6; #1;
        cmp("pin_load_tc", int'(tc), 0);
        cycle(1'b1, 1'b1, 1'b1, 6, 1'b0);
        cmp("pin_load6", int'(q), 6);
        cycle(1'b0, 1'b1, 1'b1, 6, 1'b0);
        cmp("pin_rst_over_load", int'(q), 15);

        // Hold with enable low, then load zero while idle.
        cycle(1'b1, 1'b1, 1'b0, 7, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 3, 1'b0);
        cmp("pin_hold7", int'(q), 7);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        reset = 1'b1; load = 1'b0; en = 1'b0; #1;
        cmp("pin_load0_q", int'(q), 0);
        cmp("pin_load0_zero", int'(zero), 1);
        cmp("pin_load0_tc", int'(tc), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
